// File: rtl/ex_muldiv_iter_if.sv
// Handshake and operand bundle between the EX stage and the iterative mul/div unit.
interface ex_muldiv_iter_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [DATA_W-1:0]     hi_i;
  logic [DATA_W-1:0]     lo_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;
  logic                  stallreq_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    input  result_o, ready_o, busy_o, stallreq_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    output result_o, ready_o, busy_o, stallreq_o
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside EX producing {hi,lo}.
// Define MULDIV_ACC_EN to make op 1xx accumulate ({hi,lo} +/- product) instead of plain multiply.
module ex_muldiv_iter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_iter_if.slave  mdu_io
);
  localparam int unsigned RES_W   = 2 * DATA_W;
  localparam int unsigned SUM_W   = DATA_W + MUL_BITS;
  localparam int unsigned MUL_CYC = DATA_W / MUL_BITS;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_SIGN, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]   p_q, p_d, result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic               ready_q, busy_q;
`ifdef MULDIV_ACC_EN
  logic [RES_W-1:0]   acc_q, acc_d;
`endif

  logic               is_div_in, is_div_q, sgn_q, a_neg, b_neg;
  logic [DATA_W-1:0]  a_abs, b_abs;
  logic [SUM_W-1:0]   mul_sum;
  logic [DATA_W:0]    div_trial;
  logic [RES_W-1:0]   mul_next, div_next, prod, fix_res;

  assign is_div_in = !mdu_io.op_i[2] && mdu_io.op_i[1];
  assign is_div_q  = !op_q[2] && op_q[1];
  assign sgn_q     = !op_q[0];
  assign a_neg     = sgn_q & a_q[DATA_W-1];
  assign b_neg     = sgn_q & b_q[DATA_W-1];
  assign a_abs     = a_neg ? -a_q : a_q;
  assign b_abs     = b_neg ? -b_q : b_q;

  // Shift-add: high half accumulates multiplicand * low MUL_BITS of multiplier, then shift right.
  assign mul_sum   = SUM_W'(p_q[RES_W-1:DATA_W]) + SUM_W'(a_q) * SUM_W'(p_q[MUL_BITS-1:0]);
  assign mul_next  = {mul_sum, p_q[DATA_W-1:MUL_BITS]};

  // Restoring divide: {remainder, quotient} shifts left, quotient bit enters at the bottom.
  assign div_trial = p_q[RES_W-1:DATA_W-1] - {1'b0, b_q};
  assign div_next  = div_trial[DATA_W] ? {p_q[RES_W-2:0], 1'b0}
                                       : {div_trial[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};

  assign prod      = qneg_q ? -p_q : p_q;

  always_comb begin
    fix_res = prod;
    if (is_div_q) begin
      fix_res = {rneg_q ? -p_q[RES_W-1:DATA_W] : p_q[RES_W-1:DATA_W],
                 qneg_q ? -p_q[DATA_W-1:0]     : p_q[DATA_W-1:0]};
    end
`ifdef MULDIV_ACC_EN
    else if (op_q[2]) begin
      fix_res = op_q[1] ? acc_q - prod : acc_q + prod;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
`ifdef MULDIV_ACC_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mdu_io.start_i && !mdu_io.annul_i) begin
          op_d = mdu_io.op_i;
          a_d  = mdu_io.opdata1_i;
          b_d  = mdu_io.opdata2_i;
`ifdef MULDIV_ACC_EN
          acc_d = {mdu_io.hi_i, mdu_io.lo_i};
`endif
          if (is_div_in && (mdu_io.opdata2_i == '0)) begin
            result_d = {mdu_io.opdata1_i, {DATA_W{1'b1}}};
            state_d  = S_DONE;
          end else begin
            state_d  = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        a_d    = a_abs;
        b_d    = b_abs;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        if (is_div_q) begin
          p_d     = {{DATA_W{1'b0}}, a_abs};
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = S_DIV;
        end else begin
          p_d     = {{DATA_W{1'b0}}, b_abs};
          cnt_d   = CNT_W'(MUL_CYC - 1);
          state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        p_d = (state_q == S_DIV) ? div_next : mul_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a completion in FIX.
    if (mdu_io.annul_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULDIV_ACC_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
`ifdef MULDIV_ACC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign mdu_io.result_o   = result_q;
  assign mdu_io.ready_o    = ready_q;
  assign mdu_io.busy_o     = busy_q;
  assign mdu_io.stallreq_o = mdu_io.start_i && !ready_q && !mdu_io.annul_i;
endmodule
